truth_table_sequencer: RTL and testbench
========================================

Name: truth_table_sequencer

Overview:
Sequential sweeper that drives the input vector of a combinational N-input logic function under test (e.g. the 3-input sum-of-products minterm block), walks all 2^N input rows in ascending order, and samples the function output for each row. It records the observed truth table and compares it against an expected minterm mask. It reports pass/fail, a per-row mismatch mask and the first failing row. It sits beside the combinational function as its controller and self-checker, replacing hand-written per-row stimulus.

Parameters:
N, 3, number of function inputs; rows = 2^N; legal range 1..6.
EXP, 8'hAA, expected truth table, width 2^N; bit i = expected output for input row i. Default is m(1,3,5,7).
SETTLE, 1, extra cycles each row is held before sampling; legal range 0..15.

Ports:
clk  input  1  clock, rising-edge active.
rst_n  input  1  asynchronous active-low reset.
start  input  1  begin a sweep; honoured only in IDLE or DONE.
abort  input  1  cancel a sweep in progress.
vars  output  N  input row driven to the function under test; vars[N-1] is the MSB (x), vars[0] is the LSB (z).
f_in  input  1  output of the function under test.
busy  output  1  high while a sweep is in progress.
done  output  1  one-cycle pulse when a sweep completes.
pass  output  1  1 when observed equals EXP; valid from done until the next start.
table_out  output  2^N  observed truth table; bit i = f_in sampled for row i.
mismatch  output  2^N  table_out XOR EXP, accumulated per row.
first_fail  output  N  index of the lowest mismatching row.
fail_valid  output  1  at least one mismatch recorded in the current or last sweep.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE.
  - Outputs: vars=0, busy=0, done=0, pass=0, table_out=0, mismatch=0, first_fail=0, fail_valid=0.
  - Internal row index and settle counter are cleared.
- States: IDLE, DRIVE, DONE.
- IDLE:
  - Outputs hold their previous values.
  - start=1 -> DRIVE on the next edge.
  - Entering DRIVE: vars=0, settle counter=0, table_out/mismatch/first_fail/fail_valid/pass cleared, busy=1.
- DRIVE:
  - vars = current row index.
  - The settle counter increments each cycle.
  - On the edge where counter==SETTLE:
    - table_out[row] <= f_in and mismatch[row] <= f_in ^ EXP[row].
    - On the first mismatch only: first_fail <= row and fail_valid <= 1.
  - Same edge, if row < 2^N-1: row and vars increment, counter resets to 0.
  - Same edge, if row == 2^N-1: -> DONE.
  - Each row occupies exactly SETTLE+1 cycles; a full sweep is 2^N*(SETTLE+1) cycles of busy.
- DONE (one cycle):
  - busy=0, done=1.
  - pass = (mismatch==0), including the last row's sample.
  - vars holds 2^N-1.
  - Next edge -> IDLE, or -> DRIVE if start=1 (back-to-back sweep with the same clearing as from IDLE).
- start while in DRIVE: ignored.
- abort=1 in DRIVE:
  - Next edge -> IDLE with busy=0 and vars=0.
  - done is not pulsed; pass=0.
  - table_out/mismatch/fail fields keep the partial results.
- abort in IDLE/DONE: ignored. abort and start both high in IDLE/DONE: start wins.
- Reset asserted mid-sweep: immediate return to reset values; no done pulse.
- f_in is sampled only on the sample edge. Glitches during settle cycles have no effect.
- All vectors are sized from N; no truncation (2^N ≤ 64).

Test Plan:
1. N=3, EXP=8'hAA, SETTLE=1, f_in=vars[0] (the correct reduction of m(1,3,5,7)), pulse start -> busy high 16 cycles, vars steps 0..7 every 2 cycles, done pulse, table_out=8'hAA, mismatch=0, pass=1, fail_valid=0.
2. Same setup, f_in=vars[0] except forced to 1 at row 6 -> table_out=8'hEA, mismatch=8'h40, first_fail=6, fail_valid=1, pass=0.
3. Faults at rows 2 and 5 (f_in inverted there) -> mismatch=8'h24, first_fail=2 (lowest row retained), pass=0.
4. SETTLE=0, correct function -> busy exactly 8 cycles, vars changes every cycle, pass=1. Then start held high during DONE -> second sweep begins the next cycle with results cleared, and start pulses during DRIVE do not restart the sweep.
5. abort asserted when vars=3 -> IDLE next edge, no done, busy=0, vars=0, table_out bits 0..2 retained (3'b010), pass=0.
6. rst_n pulled low asynchronously mid-sweep (between clock edges) at vars=5 -> all outputs zero immediately. After release, a fresh start completes a full sweep normally.

Source files
------------

// File: rtl/truth_table_sequencer_if.sv
// Port bundle between the truth-table sweeper and whoever starts it and
// supplies the function-under-test output.
//
// Handshake: start is a request level sampled on each rising edge; it is
// accepted only while the sweeper is idle or showing its done cycle (busy=0),
// and it is ignored while busy=1. abort is honoured only while busy=1. done is
// a one-cycle completion pulse; pass/table_out/mismatch/first_fail/fail_valid
// are stable from done until the next accepted start.
interface truth_table_sequencer_if #(
  parameter int N = 3
);
  localparam int ROWS = 1 << N;

  logic            start;
  logic            abort;
  logic            f_in;
  logic [N-1:0]    vars;
  logic            busy;
  logic            done;
  logic            pass;
  logic [ROWS-1:0] table_out;
  logic [ROWS-1:0] mismatch;
  logic [N-1:0]    first_fail;
  logic            fail_valid;
  logic [1:0]      state_dbg;

  // Controller side: requests sweeps and closes the loop through f_in.
  modport master (
    output start, abort, f_in,
    input  vars, busy, done, pass, table_out, mismatch, first_fail,
           fail_valid, state_dbg
  );

  // Sweeper side.
  modport slave (
    input  start, abort, f_in,
    output vars, busy, done, pass, table_out, mismatch, first_fail,
           fail_valid, state_dbg
  );
endinterface

// File: rtl/truth_table_sequencer.sv
// Truth-table sweeper: walks every input row of an N-input combinational
// function, holds each row SETTLE extra cycles, samples f_in on the last
// cycle of the row and compares the collected table against EXP.
module truth_table_sequencer #(
  parameter int                 N      = 3,
  parameter logic [(1<<N)-1:0]  EXP    = 8'hAA,
  parameter int                 SETTLE = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  truth_table_sequencer_if.slave bus
);
  localparam int           ROWS     = 1 << N;
  localparam logic [3:0]   SETTLE_C = SETTLE[3:0];
  localparam logic [N-1:0] LAST_ROW = {N{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state;
  logic [N-1:0]    row;
  logic [3:0]      cnt;
  logic            miss;
  logic [ROWS-1:0] mismatch_next;

  assign bus.state_dbg = state;

  // Sample-edge comparison for the current row, and the mismatch vector as it
  // will look once this row is folded in (needed for pass on the last row).
  always_comb begin
    miss               = bus.f_in ^ EXP[row];
    mismatch_next      = bus.mismatch;
    mismatch_next[row] = miss;
  end

  // Sweep FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      row            <= '0;
      cnt            <= '0;
      bus.vars       <= '0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.pass       <= 1'b0;
      bus.table_out  <= '0;
      bus.mismatch   <= '0;
      bus.first_fail <= '0;
      bus.fail_valid <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            // Same clearing whether coming from IDLE or back-to-back from DONE.
            state          <= DRIVE;
            row            <= '0;
            cnt            <= '0;
            bus.vars       <= '0;
            bus.busy       <= 1'b1;
            bus.pass       <= 1'b0;
            bus.table_out  <= '0;
            bus.mismatch   <= '0;
            bus.first_fail <= '0;
            bus.fail_valid <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end

        DRIVE: begin
          if (bus.abort) begin
            // Partial results stay visible; no done pulse.
            state    <= IDLE;
            row      <= '0;
            cnt      <= '0;
            bus.vars <= '0;
            bus.busy <= 1'b0;
            bus.pass <= 1'b0;
          end else if (cnt == SETTLE_C) begin
            bus.table_out[row] <= bus.f_in;
            bus.mismatch[row]  <= miss;
            if (miss && !bus.fail_valid) begin
              bus.first_fail <= row;
              bus.fail_valid <= 1'b1;
            end
            cnt <= '0;
            if (row == LAST_ROW) begin
              state    <= DONE;
              bus.busy <= 1'b0;
              bus.done <= 1'b1;
              bus.pass <= (mismatch_next == '0);
            end else begin
              row      <= row + 1'b1;
              bus.vars <= row + 1'b1;
            end
          end else begin
            cnt <= cnt + 4'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_truth_table_sequencer.sv
// Bench for truth_table_sequencer: one instance with SETTLE=1 and one with
// SETTLE=0, both checking m(1,3,5,7) (f = vars[0]) with injectable faults.
module tb_truth_table_sequencer;
  localparam logic [7:0] EXP_TT = 8'hAA;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  truth_table_sequencer_if #(.N(3)) if_a ();
  truth_table_sequencer_if #(.N(3)) if_b ();

  truth_table_sequencer #(.N(3), .EXP(8'hAA), .SETTLE(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(if_a.slave)
  );
  truth_table_sequencer #(.N(3), .EXP(8'hAA), .SETTLE(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(if_b.slave)
  );

  // ---------------- stimulus state ----------------
  int         s_cfg [2] = '{1, 0};
  logic       start_d [2] = '{1'b0, 1'b0};
  logic       abort_d [2] = '{1'b0, 1'b0};
  logic [7:0] fault [2] = '{8'h00, 8'h00};
  logic       glitch_en = 1'b0;
  logic       noise = 1'b0;

  int tests = 0;
  int fails = 0;

  // ---------------- behavioural model ----------------
  // A sweep is a cycle counter k from 0 to 8*(SETTLE+1); row = k/(SETTLE+1)
  // and the row is sampled on its last cycle.
  logic       sw_m   [2];
  int         k_m    [2];
  logic [2:0] vars_m [2];
  logic       busy_m [2];
  logic       done_m [2];
  logic       pass_m [2];
  logic [7:0] tab_m  [2];
  logic [7:0] mm_m   [2];
  logic [2:0] ff_m   [2];
  logic       fv_m   [2];

  // Function under test: correct reduction of m(1,3,5,7), with a fault mask
  // inverting selected rows and optional noise off the sample cycle.
  always_comb begin
    if_a.start = start_d[0];
    if_a.abort = abort_d[0];
    if_b.start = start_d[1];
    if_b.abort = abort_d[1];
    if_a.f_in  = if_a.vars[0] ^ fault[0][if_a.vars] ^
                 (glitch_en && sw_m[0] && ((k_m[0] % (s_cfg[0] + 1)) != s_cfg[0]) && noise);
    if_b.f_in  = if_b.vars[0] ^ fault[1][if_b.vars];
  end

  always @(negedge clk) noise = 1'($urandom_range(0, 1));

  // Model update on each edge, reading the inputs the DUT sees on that edge.
  int         per, r;
  logic       fval, fvl;
  logic [7:0] t, m;
  logic [2:0] ffv;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        sw_m[d] <= 1'b0; k_m[d] <= 0; vars_m[d] <= '0; busy_m[d] <= 1'b0;
        done_m[d] <= 1'b0; pass_m[d] <= 1'b0; tab_m[d] <= '0; mm_m[d] <= '0;
        ff_m[d] <= '0; fv_m[d] <= 1'b0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        per = s_cfg[d] + 1;
        t = tab_m[d]; m = mm_m[d]; ffv = ff_m[d]; fvl = fv_m[d];
        if (sw_m[d]) begin
          if (abort_d[d]) begin
            sw_m[d] <= 1'b0; k_m[d] <= 0; vars_m[d] <= '0;
            busy_m[d] <= 1'b0; pass_m[d] <= 1'b0;
          end else begin
            if ((k_m[d] % per) == per - 1) begin
              r    = k_m[d] / per;
              fval = 1'(r % 2) ^ fault[d][r];
              t[r] = fval;
              if (fval != EXP_TT[r]) begin
                m[r] = 1'b1;
                if (!fvl) begin ffv = 3'(r); fvl = 1'b1; end
              end
            end
            if (k_m[d] + 1 == 8 * per) begin
              sw_m[d] <= 1'b0; busy_m[d] <= 1'b0; done_m[d] <= 1'b1;
              pass_m[d] <= (m == 8'h00);
            end else begin
              vars_m[d] <= 3'((k_m[d] + 1) / per);
            end
            k_m[d] <= k_m[d] + 1;
            tab_m[d] <= t; mm_m[d] <= m; ff_m[d] <= ffv; fv_m[d] <= fvl;
          end
        end else begin
          done_m[d] <= 1'b0;
          if (start_d[d]) begin
            sw_m[d] <= 1'b1; k_m[d] <= 0; vars_m[d] <= '0; busy_m[d] <= 1'b1;
            pass_m[d] <= 1'b0; tab_m[d] <= '0; mm_m[d] <= '0;
            ff_m[d] <= '0; fv_m[d] <= 1'b0;
          end
        end
      end
    end
  end

  // ---------------- packed views ----------------
  // {vars[25:23], busy[22], done[21], pass[20], table[19:12], mismatch[11:4],
  //  first_fail[3:1], fail_valid[0]}
  logic [25:0] act     [2];
  logic [25:0] exp_vec [2];
  always_comb begin
    act[0] = {if_a.vars, if_a.busy, if_a.done, if_a.pass, if_a.table_out,
              if_a.mismatch, if_a.first_fail, if_a.fail_valid};
    act[1] = {if_b.vars, if_b.busy, if_b.done, if_b.pass, if_b.table_out,
              if_b.mismatch, if_b.first_fail, if_b.fail_valid};
    for (int d = 0; d < 2; d++)
      exp_vec[d] = {vars_m[d], busy_m[d], done_m[d], pass_m[d], tab_m[d],
                    mm_m[d], ff_m[d], fv_m[d]};
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    check("cycle_a", 64'(act[0]), 64'(exp_vec[0]));
    check("cycle_b", 64'(act[1]), 64'(exp_vec[1]));
  end

  // ---------------- driver tasks ----------------
  task automatic run_sweep(input int d, input logic [7:0] flt, input logic gl,
                           input int exp_busy, input logic [7:0] exp_tab,
                           input logic [7:0] exp_mm, input logic [2:0] exp_ff,
                           input logic exp_fv, input logic exp_pass);
    int   bc;
    logic got;
    fault[d]  = flt;
    glitch_en = gl;
    @(negedge clk); start_d[d] = 1'b1;
    @(negedge clk); start_d[d] = 1'b0;
    bc = 0; got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (act[d][21]) begin got = 1'b1; break; end
      if (act[d][22]) bc++;
      @(negedge clk);
    end
    check("done_seen", 64'(got), 64'(1));
    check("busy_cycles", 64'(bc), 64'(exp_busy));
    check("table_out", 64'(act[d][19:12]), 64'(exp_tab));
    check("mismatch", 64'(act[d][11:4]), 64'(exp_mm));
    check("first_fail", 64'(act[d][3:1]), 64'(exp_ff));
    check("fail_valid", 64'(act[d][0]), 64'(exp_fv));
    check("pass", 64'(act[d][20]), 64'(exp_pass));
    check("vars_last", 64'(act[d][25:23]), 64'(7));
    glitch_en = 1'b0;
  endtask

  task automatic wait_vars(input int d, input int v);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (act[d][22] && act[d][25:23] == 3'(v)) begin got = 1'b1; break; end
    end
    check("wait_vars", 64'(got), 64'(1));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int bc, dc;
    logic got;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_a", 64'(act[0]), 64'(0));
    check("reset_b", 64'(act[1]), 64'(0));
    check("reset_state", 64'(if_a.state_dbg), 64'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Correct function, with noise on settle cycles.
    run_sweep(0, 8'h00, 1'b1, 16, 8'hAA, 8'h00, 3'd0, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    // Row 6 forced high.
    run_sweep(0, 8'h40, 1'b0, 16, 8'hEA, 8'h40, 3'd6, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    // Rows 2 and 5 inverted; lowest row kept as first_fail.
    run_sweep(0, 8'h24, 1'b1, 16, 8'h8E, 8'h24, 3'd2, 1'b1, 1'b0);

    // SETTLE=0, then back-to-back sweep with start held across DONE.
    run_sweep(1, 8'h00, 1'b0, 8, 8'hAA, 8'h00, 3'd0, 1'b0, 1'b1);
    start_d[1] = 1'b1;
    @(negedge clk); start_d[1] = 1'b0;
    check("b2b_busy", 64'(act[1][22]), 64'(1));
    check("b2b_cleared", 64'(act[1][19:4]), 64'(0));
    check("b2b_vars", 64'(act[1][25:23]), 64'(0));
    bc = 1; got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (act[1][21]) begin got = 1'b1; break; end
      if (act[1][22]) bc++;
      start_d[1] = (bc == 3 || bc == 5);
    end
    start_d[1] = 1'b0;
    check("b2b_done_seen", 64'(got), 64'(1));
    check("b2b_busy_cycles", 64'(bc), 64'(8));
    check("b2b_pass", 64'(act[1][20]), 64'(1));

    // Abort at row 3.
    fault[0] = 8'h00;
    @(negedge clk); start_d[0] = 1'b1;
    @(negedge clk); start_d[0] = 1'b0;
    wait_vars(0, 3);
    abort_d[0] = 1'b1;
    @(negedge clk); abort_d[0] = 1'b0;
    check("abort_busy", 64'(act[0][22]), 64'(0));
    check("abort_vars", 64'(act[0][25:23]), 64'(0));
    check("abort_pass", 64'(act[0][20]), 64'(0));
    check("abort_table", 64'(act[0][19:12]), 64'(8'h02));
    check("abort_state", 64'(if_a.state_dbg), 64'(0));
    dc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (act[0][21]) dc++;
    end
    check("abort_no_done", 64'(dc), 64'(0));

    // Asynchronous reset mid-sweep at row 5.
    @(negedge clk); start_d[0] = 1'b1;
    @(negedge clk); start_d[0] = 1'b0;
    wait_vars(0, 5);
    #3 rst_n = 1'b0;
    #1;
    check("async_reset", 64'(act[0]), 64'(0));
    check("async_reset_state", 64'(if_a.state_dbg), 64'(0));
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_sweep(0, 8'h00, 1'b0, 16, 8'hAA, 8'h00, 3'd0, 1'b0, 1'b1);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
